// File: rtl/channel_serializer.sv
// channel_serializer: turns one 16-channel filterbank frame (16 x sfix37_En32)
// into a ready/valid stream of OUT_W-bit signed samples, one channel per beat.
// Each sample is requantized by dropping FRAC_DROP LSBs and then saturated.
// One frame can be queued behind the frame being sent. A frame arriving while
// the queue is full is dropped, and the sticky overrun flag is set.
// Optional build macro: CHSER_ROUND_EN. When it is defined, rounding is
// round-half-up before the shift. When it is undefined, the value is truncated.
module channel_serializer #(
  parameter int OUT_W     = 16,
  parameter int FRAC_DROP = 17
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    clk_enable,
  input  logic                    frame_strobe,
  input  logic [591:0]            chan_in,
  output logic signed [OUT_W-1:0] out_data,
  output logic [3:0]              out_chan,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic                    sat_flag,
  output logic                    overrun,
  input  logic                    overrun_clr
);

  localparam int IN_W  = 37;
  localparam int N_CH  = 16;
  localparam int ACC_W = 38;

  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
`ifdef CHSER_ROUND_EN
  localparam logic signed [ACC_W-1:0] RND_HALF =
    {{(ACC_W-1){1'b0}}, 1'b1} << (FRAC_DROP-1);
`endif

  typedef enum logic {IDLE, SEND} state_t;

  state_t                  state;
  logic [3:0]              idx;
  logic                    pend_vld;
  logic signed [IN_W-1:0]  active_bank  [N_CH];
  logic signed [IN_W-1:0]  pending_bank [N_CH];

  logic                    strobe_q;
  logic                    beat;
  logic                    last_beat;
  logic                    load_active;
  logic                    promote;
  logic                    load_pending;
  logic                    drop;
  logic signed [ACC_W-1:0] shifted;

  // Sign-extend into the wider accumulator, optionally add half an output LSB, then shift arithmetically
  function automatic logic signed [ACC_W-1:0] requant_shift(input logic signed [IN_W-1:0] sample);
    logic signed [ACC_W-1:0] acc;
    acc = $signed({sample[IN_W-1], sample});
`ifdef CHSER_ROUND_EN
    acc = acc + RND_HALF;
`endif
    return acc >>> FRAC_DROP;
  endfunction

  function automatic logic sat_hit(input logic signed [ACC_W-1:0] v);
    return (v > SAT_MAX) || (v < SAT_MIN);
  endfunction

  function automatic logic signed [OUT_W-1:0] saturate(input logic signed [ACC_W-1:0] v);
    logic signed [OUT_W-1:0] r;
    if (v > SAT_MAX)      r = SAT_MAX[OUT_W-1:0];
    else if (v < SAT_MIN) r = SAT_MIN[OUT_W-1:0];
    else                  r = v[OUT_W-1:0];
    return r;
  endfunction

  // Frame handoff decisions: who loads the active and pending banks this cycle
  always_comb begin
    strobe_q     = clk_enable & frame_strobe;
    beat         = (state == SEND) & out_ready;
    last_beat    = beat & (idx == 4'd15);
    load_active  = strobe_q & ((state == IDLE) | (last_beat & ~pend_vld));
    promote      = last_beat & pend_vld;
    load_pending = strobe_q & (state == SEND) &
                   ((~last_beat & ~pend_vld) | (last_beat & pend_vld));
    drop         = strobe_q & (state == SEND) & ~last_beat & pend_vld;
  end

  // Control state: FSM, channel index, pending occupancy and sticky overrun
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      idx      <= 4'd0;
      pend_vld <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (strobe_q) begin
            state <= SEND;
            idx   <= 4'd0;
          end
        end
        SEND: begin
          if (last_beat) begin
            idx <= 4'd0;
            // Without a queued or arriving frame, the stream ends here
            if (!pend_vld && !strobe_q) state <= IDLE;
          end else if (beat) begin
            idx <= idx + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase

      if (load_pending)  pend_vld <= 1'b1;
      else if (promote)  pend_vld <= 1'b0;

      // An overrun in the same cycle as a clear wins, so no drop goes unreported
      if (drop)             overrun <= 1'b1;
      else if (overrun_clr) overrun <= 1'b0;
    end
  end

  // Sample banks; data only, contents are meaningless until a frame is loaded
  always_ff @(posedge clock) begin
    for (int k = 0; k < N_CH; k++) begin
      if (load_active)  active_bank[k]  <= $signed(chan_in[k*IN_W +: IN_W]);
      else if (promote) active_bank[k]  <= pending_bank[k];
      if (load_pending) pending_bank[k] <= $signed(chan_in[k*IN_W +: IN_W]);
    end
  end

  // Output stage: requantize the current channel combinationally, gated to zero while idle
  always_comb begin
    shifted   = requant_shift(active_bank[idx]);
    out_valid = (state == SEND);
    out_chan  = idx;
    out_last  = out_valid & (idx == 4'd15);
    out_data  = out_valid ? saturate(shifted) : '0;
    sat_flag  = out_valid & sat_hit(shifted);
  end

endmodule
